// File: rtl/branch_resolve_unit_if.sv
// Decode-to-redirect bus of the branch resolve stage: the instruction/prediction
// inputs with their valid/ready handshake, the resolved result with its own
// handshake, and the statistics outputs.
interface branch_resolve_unit_if #(
  parameter int PC_W  = 36,
  parameter int IMM_W = 25,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       branch_jump;
  logic [2:0]       branch_type;
  logic             branch_register;
  logic [IMM_W-1:0] immediate;
  logic [PC_W-1:0]  register;
  logic [PC_W-1:0]  pc;
  logic [5:0]       cond_flags;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic             out_valid;
  logic             out_ready;
  logic [PC_W-1:0]  pc_next;
  logic             taken;
  logic             mispredict;
  logic             flushing;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // Decode side / redirect consumer: drives instructions, accepts results.
  modport master (
    output in_valid, branch_jump, branch_type, branch_register, immediate,
           register, pc, cond_flags, pred_taken, pred_target, out_ready,
    input  in_ready, out_valid, pc_next, taken, mispredict, flushing,
           branch_cnt, mispred_cnt
  );

  // The resolve stage itself.
  modport slave (
    input  in_valid, branch_jump, branch_type, branch_register, immediate,
           register, pc, cond_flags, pred_taken, pred_target, out_ready,
    output in_ready, out_valid, pc_next, taken, mispredict, flushing,
           branch_cnt, mispred_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution stage. Resolves condition and target in one cycle,
// registers the result with a redirect flag on mispredict, then squashes the
// next FLUSH_CYCLES accepted (wrong-path) instructions. Keeps saturating
// branch and mispredict counters.
module branch_resolve_unit #(
  parameter int PC_W         = 36,
  parameter int IMM_W        = 25,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  branch_resolve_unit_if.slave   bus
);

  typedef enum logic {RUN, FLUSH} state_t;

  // Sign-extend the immediate field to full pc width.
  function automatic logic signed [PC_W-1:0] sext_imm(input logic [IMM_W-1:0] imm);
    return PC_W'($signed(imm));
  endfunction

  // Counter increment that sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  state_t                  state, state_n;
  logic [3:0]              flush_cnt, flush_cnt_n;

  logic                    accept;
  logic                    load;
  logic                    is_ctrl_p0;
  logic                    taken_p0;
  logic                    mispred_p0;
  logic signed [PC_W-1:0]  target_p0;
  logic [PC_W-1:0]         pc_next_p0;

  logic                    vld_p1;
  logic [PC_W-1:0]         pc_next_p1;
  logic                    taken_p1;
  logic                    mispred_p1;
  logic [CNT_W-1:0]        branch_cnt_q;
  logic [CNT_W-1:0]        mispred_cnt_q;

  assign bus.in_ready = !vld_p1 | bus.out_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  // Younger instructions arriving during the flush window are never loaded.
  assign load         = accept & (state == RUN);

  // ---- stage p0: combinational resolve of the presented instruction ----
  // Condition evaluation, target arithmetic and prediction compare.
  always_comb begin
    is_ctrl_p0 = (bus.branch_jump == 2'b01) | (bus.branch_jump == 2'b10);
    taken_p0   = 1'b0;
    if (bus.branch_jump == 2'b01) begin
      taken_p0 = 1'b1;
    end else if (bus.branch_jump == 2'b10) begin
      case (bus.branch_type)
        3'd0:    taken_p0 = bus.cond_flags[0];
        3'd1:    taken_p0 = bus.cond_flags[1];
        3'd2:    taken_p0 = bus.cond_flags[2];
        3'd3:    taken_p0 = bus.cond_flags[3];
        3'd4:    taken_p0 = bus.cond_flags[4];
        3'd5:    taken_p0 = bus.cond_flags[5];
        default: taken_p0 = 1'b0;
      endcase
    end
    target_p0  = $signed(bus.pc) + sext_imm(bus.immediate)
               + (bus.branch_register ? $signed(bus.register) : $signed({PC_W{1'b0}}));
    pc_next_p0 = taken_p0 ? target_p0 : bus.pc;
    mispred_p0 = (taken_p0 != bus.pred_taken)
               | (taken_p0 & bus.pred_taken & (target_p0 != $signed(bus.pred_target)));
  end

  // ---- stage p1: result register and statistics ----
  // Output register: load on a non-squashed accept, otherwise drain when consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      pc_next_p1 <= '0;
      taken_p1   <= 1'b0;
      mispred_p1 <= 1'b0;
    end else if (load) begin
      vld_p1     <= 1'b1;
      pc_next_p1 <= pc_next_p0;
      taken_p1   <= taken_p0;
      mispred_p1 <= mispred_p0;
    end else if (bus.out_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  // Saturating statistics, counted only for delivered instructions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_cnt_q  <= '0;
      mispred_cnt_q <= '0;
    end else begin
      if (load & is_ctrl_p0) branch_cnt_q  <= sat_inc(branch_cnt_q);
      if (load & mispred_p0) mispred_cnt_q <= sat_inc(mispred_cnt_q);
    end
  end

  // Flush FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= 4'd0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Flush FSM next state: enter on a delivered mispredict, count down accepts.
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    case (state)
      RUN: begin
        if (load & mispred_p0) begin
          state_n     = FLUSH;
          flush_cnt_n = 4'(FLUSH_CYCLES);
        end
      end
      FLUSH: begin
        if (accept) begin
          if (flush_cnt <= 4'd1) begin
            state_n     = RUN;
            flush_cnt_n = 4'd0;
          end else begin
            flush_cnt_n = flush_cnt - 4'd1;
          end
        end
      end
      default: begin
        state_n     = RUN;
        flush_cnt_n = 4'd0;
      end
    endcase
  end

  assign bus.out_valid   = vld_p1;
  assign bus.pc_next     = pc_next_p1;
  assign bus.taken       = taken_p1;
  assign bus.mispredict  = mispred_p1;
  assign bus.flushing    = (state == FLUSH);
  assign bus.branch_cnt  = branch_cnt_q;
  assign bus.mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed bench for branch_resolve_unit: resolve, flush window, backpressure,
// wrap-around target and reset during a flush.
module tb_branch_resolve_unit;
  localparam int PC_W  = 36;
  localparam int IMM_W = 25;
  localparam int CNT_W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  branch_resolve_unit_if #(.PC_W(PC_W), .IMM_W(IMM_W), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(
    .PC_W(PC_W), .IMM_W(IMM_W), .FLUSH_CYCLES(2), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; leave time 1 unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] bj, input logic [2:0] bt, input logic br,
                       input logic [IMM_W-1:0] imm, input logic [PC_W-1:0] rg,
                       input logic [PC_W-1:0] pcv, input logic [5:0] flags,
                       input logic pt, input logic [PC_W-1:0] ptgt);
    bus.in_valid        = 1'b1;
    bus.branch_jump     = bj;
    bus.branch_type     = bt;
    bus.branch_register = br;
    bus.immediate       = imm;
    bus.register        = rg;
    bus.pc              = pcv;
    bus.cond_flags      = flags;
    bus.pred_taken      = pt;
    bus.pred_target     = ptgt;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 3'd0, 1'b0, '0, '0, '0, 6'd0, 1'b0, '0);
    bus.in_valid = 1'b0;
    step(); step();

    // Reset state
    chk("rst_out_valid",  bus.out_valid,   0);
    chk("rst_pc_next",    bus.pc_next,     0);
    chk("rst_taken",      bus.taken,       0);
    chk("rst_mispredict", bus.mispredict,  0);
    chk("rst_flushing",   bus.flushing,    0);
    chk("rst_branch_cnt", bus.branch_cnt,  0);
    chk("rst_mispred_cnt",bus.mispred_cnt, 0);
    chk("rst_in_ready",   bus.in_ready,    1);
    rst_n = 1'b1;
    step();

    // Jump, correctly predicted
    drive(2'b01, 3'd0, 1'b0, 25'h10, '0, 36'h100, 6'd0, 1'b1, 36'h110);
    step();
    chk("jmp_out_valid",  bus.out_valid,  1);
    chk("jmp_pc_next",    bus.pc_next,    36'h110);
    chk("jmp_taken",      bus.taken,      1);
    chk("jmp_mispredict", bus.mispredict, 0);
    chk("jmp_branch_cnt", bus.branch_cnt, 1);

    // Branch ez not taken, predicted not taken
    drive(2'b10, 3'd1, 1'b0, 25'h0, '0, 36'h200, 6'b000000, 1'b0, '0);
    step();
    chk("bnt_pc_next",    bus.pc_next,    36'h200);
    chk("bnt_taken",      bus.taken,      0);
    chk("bnt_mispredict", bus.mispredict, 0);
    chk("bnt_branch_cnt", bus.branch_cnt, 2);

    // Branch ez taken with negative offset, predicted not taken -> mispredict
    drive(2'b10, 3'd1, 1'b0, 25'h1FFFFFF, '0, 36'h200, 6'b000010, 1'b0, '0);
    step();
    chk("bmp_pc_next",     bus.pc_next,     36'h1FF);
    chk("bmp_taken",       bus.taken,       1);
    chk("bmp_mispredict",  bus.mispredict,  1);
    chk("bmp_mispred_cnt", bus.mispred_cnt, 1);
    chk("bmp_branch_cnt",  bus.branch_cnt,  3);
    chk("bmp_flushing",    bus.flushing,    1);

    // Three back-to-back inputs: first two squashed, third delivered
    drive(2'b01, 3'd0, 1'b0, 25'h20, '0, 36'h300, 6'd0, 1'b1, 36'h320);
    step();
    chk("fl1_out_valid", bus.out_valid, 0);
    chk("fl1_flushing",  bus.flushing,  1);
    drive(2'b01, 3'd0, 1'b0, 25'h30, '0, 36'h380, 6'd0, 1'b0, '0);
    step();
    chk("fl2_out_valid",  bus.out_valid,  0);
    chk("fl2_flushing",   bus.flushing,   0);
    chk("fl2_branch_cnt", bus.branch_cnt, 3);
    drive(2'b01, 3'd0, 1'b0, 25'h40, '0, 36'h400, 6'd0, 1'b1, 36'h440);
    step();
    chk("fl3_out_valid",   bus.out_valid,   1);
    chk("fl3_pc_next",     bus.pc_next,     36'h440);
    chk("fl3_mispredict",  bus.mispredict,  0);
    chk("fl3_branch_cnt",  bus.branch_cnt,  4);
    chk("fl3_mispred_cnt", bus.mispred_cnt, 1);

    // Backpressure: hold three cycles, then drain and accept together
    bus.out_ready = 1'b0;
    drive(2'b01, 3'd0, 1'b0, 25'h8, '0, 36'h500, 6'd0, 1'b1, 36'h508);
    #1;
    chk("bp_in_ready0", bus.in_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_in_ready", bus.in_ready,  0);
      chk("bp_out_valid",bus.out_valid, 1);
      chk("bp_pc_next",  bus.pc_next,   36'h440);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", bus.in_ready, 1);
    step();
    chk("bp_nobubble_valid", bus.out_valid,  1);
    chk("bp_nobubble_pc",    bus.pc_next,    36'h508);
    chk("bp_branch_cnt",     bus.branch_cnt, 5);
    bus.in_valid = 1'b0;
    step();
    chk("bp_drained", bus.out_valid, 0);

    // Target wrap-around with register operand
    drive(2'b01, 3'd0, 1'b1, 25'h1, 36'h1, 36'hFFFFFFFFF, 6'd0, 1'b1, 36'h1);
    step();
    chk("wrap_pc_next",    bus.pc_next,    36'h1);
    chk("wrap_taken",      bus.taken,      1);
    chk("wrap_mispredict", bus.mispredict, 0);

    // Non-control predicted taken is a mispredict, not a counted branch
    drive(2'b00, 3'd0, 1'b0, 25'h4, '0, 36'h600, 6'h3F, 1'b1, 36'h604);
    step();
    chk("nc_pc_next",     bus.pc_next,     36'h600);
    chk("nc_taken",       bus.taken,       0);
    chk("nc_mispredict",  bus.mispredict,  1);
    chk("nc_branch_cnt",  bus.branch_cnt,  6);
    chk("nc_mispred_cnt", bus.mispred_cnt, 2);
    chk("nc_flushing",    bus.flushing,    1);

    // Reset asserted mid-flush with the result still held
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    step();
    chk("prerst_valid",    bus.out_valid, 1);
    chk("prerst_flushing", bus.flushing,  1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid",   bus.out_valid,   0);
    chk("mrst_pc_next",     bus.pc_next,     0);
    chk("mrst_mispredict",  bus.mispredict,  0);
    chk("mrst_flushing",    bus.flushing,    0);
    chk("mrst_branch_cnt",  bus.branch_cnt,  0);
    chk("mrst_mispred_cnt", bus.mispred_cnt, 0);
    step();
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // First input after reset resolves normally (branch gz taken)
    drive(2'b10, 3'd3, 1'b0, 25'h100, '0, 36'h700, 6'b001000, 1'b1, 36'h800);
    step();
    chk("post_out_valid",  bus.out_valid,  1);
    chk("post_pc_next",    bus.pc_next,    36'h800);
    chk("post_taken",      bus.taken,      1);
    chk("post_mispredict", bus.mispredict, 0);
    chk("post_branch_cnt", bus.branch_cnt, 1);

    // Branch type 6 never taken even with all flags set
    drive(2'b10, 3'd6, 1'b0, 25'h10, '0, 36'h900, 6'h3F, 1'b0, '0);
    step();
    chk("never_pc_next",    bus.pc_next,    36'h900);
    chk("never_taken",      bus.taken,      0);
    chk("never_mispredict", bus.mispredict, 0);
    chk("never_branch_cnt", bus.branch_cnt, 2);
    bus.in_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
Pipelined, parametrised branch/jump resolution stage placed between decode and fetch redirect. It evaluates the branch condition against the condition-code flags and computes the target. It compares the result against the fetch-stage prediction and raises a registered redirect on mispredict. It then runs a wrong-path flush window, discarding younger in-flight instructions. It also keeps saturating branch/mispredict statistics counters.

Parameters:
PC_W, 36, width of pc, register operand and target
IMM_W, 25, width of immediate field; sign-extended to PC_W
FLUSH_CYCLES, 2, number of accepted-input slots discarded after a mispredict (1..15)
CNT_W, 16, width of each statistics counter

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  decode presents an instruction
in_ready  out  1  stage can accept; = !out_valid | out_ready
branch_jump  in  2  01 = jump, 10 = conditional branch, 00/11 = non-control
branch_type  in  3  000 nz, 001 ez, 010 lz, 011 gz, 100 le, 101 ge, 110/111 never taken
branch_register  in  1  1: target = pc + register + sext(immediate); 0: target = pc + sext(immediate)
immediate  in  IMM_W  offset, two's complement
register  in  PC_W  register operand
pc  in  PC_W  pc of instruction (already fall-through value)
cond_flags  in  6  {ge,le,gz,lz,ez,nz}, bit0 = nz
pred_taken  in  1  fetch prediction: taken
pred_target  in  PC_W  fetch prediction: target
out_valid  out  1  result register valid
out_ready  in  1  consumer accepts result
pc_next  out  PC_W  resolved next pc
taken  out  1  control transfer resolved taken
mispredict  out  1  registered; qualified by out_valid
flushing  out  1  high while in FLUSH state
branch_cnt  out  CNT_W  accepted control instructions, saturating
mispred_cnt  out  CNT_W  mispredicts, saturating

Behaviour:
- Reset (async, rst_n low): out_valid=0, pc_next=0, taken=0, mispredict=0, flushing=0, branch_cnt=0, mispred_cnt=0, state=RUN, flush counter=0. A reset mid-flush returns to RUN immediately.
- Accept = in_valid & in_ready. Latency is 1 cycle: the accepted instruction appears on the output the next cycle. The output register holds while out_valid & !out_ready.
- Target arithmetic: sext(immediate) to PC_W, add modulo 2^PC_W (wrap, no overflow flag).
- taken: jump -> 1; branch -> cond_flags[branch_type] for types 0-5, 0 for 6/7; non-control -> 0.
- pc_next = taken ? target : pc.
- mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target). Non-control with pred_taken=1 is also a mispredict.
- FSM RUN: an accepted input loads the output register. If it is a mispredict, go to FLUSH with counter = FLUSH_CYCLES.
- FSM FLUSH: in_ready follows the same rule. Each accepted input is discarded: no output load, no counters, and the counter decrements. At counter 1 with an accept, return to RUN. flushing=1 throughout.
- A cycle with no accept does not decrement the counter.
- The mispredicting instruction itself is always delivered; only younger ones are squashed.
- branch_cnt increments on accepted non-discarded branch_jump in {01,10}. mispred_cnt increments on accepted non-discarded mispredicts. Both saturate at all-ones.
- Simultaneous output drain and new accept in the same cycle: the register is overwritten with the new result (full throughput, no bubble).

Test Plan:
- Jump, branch_register=0, pc=0x100, imm=0x10, pred_taken=1, pred_target=0x110 -> next cycle out_valid=1, pc_next=0x110, taken=1, mispredict=0, branch_cnt=1.
- Branch ez (type 001), cond_flags ez=0, pc=0x200, pred_taken=0 -> pc_next=0x200, taken=0, mispredict=0. Repeat with imm=0x1FFFFFF, ez=1 -> pc_next=0x1FF, mispredict=1.
- Mispredict followed by 3 back-to-back inputs, FLUSH_CYCLES=2 -> mispredict delivered; the next 2 inputs are dropped with flushing=1; the 3rd appears on the output; mispred_cnt=1.
- Hold out_ready=0 for 3 cycles with out_valid=1 -> in_ready=0, pc_next stable. Release -> drains, and a new accept in the same cycle yields no bubble.
- pc=0xFFFFFFFFF, branch_register=1, register=1, imm=1, taken -> pc_next=0x000000001 (wrap).
- Assert rst_n low mid-FLUSH while out_valid=1 -> all outputs 0 immediately, flushing=0. After release, the first input resolves normally.
